// File: rtl/hms_clock_core.sv
// hms_clock_core: hours/minutes/seconds timekeeper with debounced
// mode / position / increment buttons and an in-place SETUP editor.
// Optional alarm output is compiled in when HMS_CLOCK_ALARM_EN is defined.
module hms_clock_core #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned DBNC_CYCLES = 500000,
  parameter int unsigned HOUR_MAX    = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
`ifdef HMS_CLOCK_ALARM_EN
  input  logic       i_alm_on,
  input  logic [4:0] i_alm_hour,
  input  logic [5:0] i_alm_min,
  output logic       o_alarm,
`endif
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_mode,
  output logic [1:0] o_position,
  output logic       o_tick,
  output logic       o_day_wrap
);

  localparam int unsigned PW = $clog2(CLK_HZ + 1);
  localparam int unsigned DW = $clog2(DBNC_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DBNC_LAST  = DW'(DBNC_CYCLES - 1);
  localparam logic [4:0]    HOUR_LAST  = 5'(HOUR_MAX);

  // Button slots inside the packed button vectors.
  localparam int BTN_MODE = 0;
  localparam int BTN_POS  = 1;
  localparam int BTN_INC  = 2;

  typedef enum logic {MODE_CLOCK = 1'b0, MODE_SETUP = 1'b1} mode_e;
  typedef enum logic [1:0] {POS_SEC = 2'd0, POS_MIN = 2'd1, POS_HOUR = 2'd2} pos_e;

  logic [2:0]    sync1, sync2, filt, btn_press;
  logic [DW-1:0] dbnc_cnt [3];
  logic [PW-1:0] presc, presc_n;
  logic          sec_tick;
  mode_e         mode_q, mode_n;
  pos_e          pos_q, pos_n;
  logic [5:0]    sec_n, min_n;
  logic [4:0]    hour_n;
  logic          day_wrap_n;

  // Two-flop synchroniser; idles at 1 so reset looks like released buttons.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {i_sw_inc, i_sw_pos, i_sw_mode};
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level after DBNC_CYCLES consecutive differing samples;
  // a press is a one-cycle pulse when the accepted level falls to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt      <= '1;
      btn_press <= '0;
      // NOTE: this counter array is plain control state, so every entry is reset like any flop.
      for (int i = 0; i < 3; i++) dbnc_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        btn_press[i] <= 1'b0;
        if (sync2[i] == filt[i]) begin
          dbnc_cnt[i] <= '0;
        end else if (dbnc_cnt[i] == DBNC_LAST) begin
          filt[i]      <= sync2[i];
          btn_press[i] <= ~sync2[i];
          dbnc_cnt[i]  <= '0;
        end else begin
          dbnc_cnt[i] <= dbnc_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A second elapses only while running in CLOCK mode.
  assign sec_tick = (mode_q == MODE_CLOCK) && (presc == PRESC_LAST);

  // Prescaler next value: held at 0 in SETUP and zeroed by a mode press, so
  // the first tick after leaving SETUP comes a full CLK_HZ cycles later.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    presc_n = presc + 1'b1;
    if (mode_q == MODE_SETUP || btn_press[BTN_MODE] || sec_tick) presc_n = '0;
  end

  // Time next value: tick carries through sec/min/hour; SETUP increments
  // touch only the selected field and never carry. A mode press masks inc.
  always_comb begin
    sec_n      = o_sec;
    min_n      = o_min;
    hour_n     = o_hour;
    day_wrap_n = 1'b0;
    if (sec_tick) begin
      if (o_sec == 6'd59) begin
        sec_n = '0;
        if (o_min == 6'd59) begin
          min_n = '0;
          if (o_hour == HOUR_LAST) begin
            hour_n     = '0;
            day_wrap_n = 1'b1;
          end else begin
            hour_n = o_hour + 5'd1;
          end
        end else begin
          min_n = o_min + 6'd1;
        end
      end else begin
        sec_n = o_sec + 6'd1;
      end
    end else if (mode_q == MODE_SETUP && !btn_press[BTN_MODE] && btn_press[BTN_INC]) begin
      case (pos_q)
        POS_SEC:  sec_n  = (o_sec == 6'd59) ? 6'd0 : o_sec + 6'd1;
        POS_MIN:  min_n  = (o_min == 6'd59) ? 6'd0 : o_min + 6'd1;
        POS_HOUR: hour_n = (o_hour == HOUR_LAST) ? 5'd0 : o_hour + 5'd1;
        default:  ;
      endcase
    end
  end

  // Mode/position next state: mode press wins over position press.
  always_comb begin
    mode_n = mode_q;
    pos_n  = pos_q;
    if (btn_press[BTN_MODE]) begin
      mode_n = (mode_q == MODE_CLOCK) ? MODE_SETUP : MODE_CLOCK;
      if (mode_q == MODE_CLOCK) pos_n = POS_SEC;
    end else if (mode_q == MODE_SETUP && btn_press[BTN_POS]) begin
      case (pos_q)
        POS_SEC: pos_n = POS_MIN;
        POS_MIN: pos_n = POS_HOUR;
        default: pos_n = POS_SEC;
      endcase
    end
  end

  // State register for time, prescaler, mode/position and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      o_sec      <= '0;
      o_min      <= '0;
      o_hour     <= '0;
      mode_q     <= MODE_CLOCK;
      pos_q      <= POS_SEC;
      o_tick     <= 1'b0;
      o_day_wrap <= 1'b0;
    end else begin
      presc      <= presc_n;
      o_sec      <= sec_n;
      o_min      <= min_n;
      o_hour     <= hour_n;
      mode_q     <= mode_n;
      pos_q      <= pos_n;
      o_tick     <= sec_tick;
      o_day_wrap <= day_wrap_n;
    end
  end

  // Mode and position outputs come straight from their registers.
  assign o_mode     = mode_q;
  assign o_position = pos_q;

`ifdef HMS_CLOCK_ALARM_EN
  logic       alarm_q;
  logic [5:0] alarm_ticks;
  logic       alarm_hit;

  assign alarm_hit = sec_tick && (sec_n == 6'd0) && (min_n == i_alm_min) && (hour_n == i_alm_hour);

  // Alarm rings from the matching tick for 60 ticks; disable or any press silences it.
  always_ff @(posedge clk) begin
    if (rst || !i_alm_on || (|btn_press)) begin
      alarm_q     <= 1'b0;
      alarm_ticks <= '0;
    end else if (alarm_hit) begin
      alarm_q     <= 1'b1;
      alarm_ticks <= '0;
    end else if (alarm_q && sec_tick) begin
      if (alarm_ticks == 6'd59) alarm_q <= 1'b0;
      alarm_ticks <= alarm_ticks + 6'd1;
    end
  end

  assign o_alarm = alarm_q;
`endif

endmodule
